ifu_fetch_queue: RTL
====================

# ifu_fetch_queue

Decoupled instruction-fetch front end for the pipelined MIPS core. It sits directly upstream of the IF/ID register, replacing the single-cycle instruction ROM path with a variable-latency instruction-memory port. It keeps a small in-order prefetch queue of {PC, instruction} pairs. It absorbs IF/ID hazard stalls and flushes cleanly on any jump, branch or jump-register redirect from the control path.

## Interface
- DEPTH, 4: queue entries; must be a power of two, at least 2.
- RESET_PC, 32'h0000_3000: first fetch address after reset.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect  in  1  taken jump/branch/jr this cycle; flush and refetch.
- redirect_pc  in  32  new fetch PC; word aligned.
- stall  in  1  IF/ID hold (HazardCtr); the head entry must not be consumed.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle (req & gnt = handshake).
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- out_valid  out  1  head entry present.
- out_pc  out  32  PC of head entry.
- out_ir  out  32  instruction at head; 32'h0 (NOP) when out_valid=0.

## Operation
- Fetch PC register `fpc`:
  - Loads RESET_PC on reset.
  - Increments by 4 on each accepted request.
  - Loads redirect_pc on redirect; this overrides the same-cycle increment.
- Credit rule: imem_req = 1 only when (count + outstanding) < DEPTH, no redirect this cycle, and reset is deasserted. No response is ever dropped for lack of space.
- `outstanding` counter (0..DEPTH):
  - +1 on grant.
  - −1 on rvalid.
  - Both on the same cycle: unchanged.
- Response handling:
  - A response whose drop_cnt = 0 is pushed as {pc_of_request, rdata}.
  - Request PCs are held in a PC shadow FIFO of DEPTH entries, popped on each rvalid.
- Pop: the head is popped when out_valid & !stall & !redirect.
- Push and pop may occur in the same cycle. The count is then unchanged, and a full queue stays full without overflow.
- Redirect, evaluated in this cycle:
  - Queue cleared: count = 0, pointers reset.
  - drop_cnt ← outstanding − (rvalid ? 1 : 0). The response arriving this cycle is discarded.
  - PC shadow FIFO cleared.
  - fpc ← redirect_pc.
  - Subsequent rvalids while drop_cnt > 0 decrement drop_cnt and are discarded.
  - New requests may issue the cycle after the redirect, even while drop_cnt > 0. The in-order return guarantees that stale responses arrive first.
- Redirect during stall: the flush still occurs and out_valid = 0 the next cycle.
- Redirect while empty: same behaviour.
- A redirect with redirect_pc[1:0] ≠ 0 is illegal; bits [1:0] are forced to 0.

## Timing
- Reset values:
  - imem_req = 0, imem_addr = RESET_PC.
  - out_valid = 0, out_pc = 0, out_ir = 0.
  - count, outstanding and drop_cnt = 0.
- imem_req rises in the first cycle after reset deasserts.
- With a 1-cycle memory:
  - Request granted in cycle N, rvalid in N+1.
  - Entry is visible on out_* in N+2. There is no bypass; outputs are registered queue-head reads.
- Steady state with 1-cycle memory and no stall: one instruction per cycle. out_pc increments by 4 each cycle.
- Redirect asserted in cycle R:
  - First request to redirect_pc in cycle R+1.
  - First valid output no earlier than R+3.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Any responses still returning after release are the memory's responsibility; the memory is reset by the same signal.

## Structure
- Shared package `fetch_pkg`: FETCH_DEPTH default, RESET_PC, NOP_INSTR = 32'h0, and the fetch_entry_t {pc[31:0], ir[31:0]} typedef.
- One sub-module, `fq_ring`: a parameterised circular buffer with push/pop/flush and count. It is instantiated twice: once as the 64-bit entry queue and once as the 32-bit PC shadow FIFO.
- Credit, drop and fpc logic live in the top module.

## Test plan
- Reset release, 1-cycle memory, no stall:
  - imem_addr = 0x3000, 0x3004, 0x3008… on consecutive cycles.
  - out_valid rises 2 cycles after the first grant.
  - out_pc = 0x3000 with the matching rdata.
- stall held for 10 cycles:
  - count saturates at 4 and imem_req drops.
  - out_pc stays at the head value.
  - After release, 4 entries drain in order with no gaps or duplicates.
- 3-cycle memory latency, redirect to 0x4000 while 2 responses are outstanding:
  - Both stale responses are discarded.
  - The next out_pc is 0x4000, and no instruction from 0x3xxx appears after the redirect.
- Redirect in the same cycle as a push and a pop with a full queue:
  - The queue becomes empty.
  - out_valid = 0 the next cycle, with no underflow or overflow assertion.
- Reset asserted mid-stream with 2 outstanding requests:
  - All outputs return to their reset values asynchronously.
  - After release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Contents:
//   FETCH_DEPTH   default prefetch queue depth (power of two, >= 2)
//   RESET_PC      first fetch address after reset
//   NOP_INSTR     instruction presented when no entry is valid
//   fetch_entry_t {pc, ir} pair held in the prefetch queue
//   alignPc       clears the byte-offset bits of a fetch address
package fetch_pkg;

    localparam int unsigned FETCH_DEPTH = 4;
    localparam logic [31:0] RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    // Word-align a PC; misaligned redirect targets are illegal and get truncated
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fq_ring.sv
// Parameterised circular buffer with push/pop/flush and an occupancy count.
// Used both as the {pc, ir} prefetch queue and as the request-PC shadow FIFO.
// Ports:
//   clk, reset     clock and asynchronous active-low reset
//   flush          empties the buffer; wins over push and pop
//   push, pushData write one word at the tail
//   pop            retire the head word
//   headData       current head word (combinational read of the storage)
//   count          number of valid words, 0..DEPTH
module fq_ring
    import fetch_pkg::*;
#(
    parameter int unsigned  WIDTH = 32,
    parameter int unsigned  DEPTH = FETCH_DEPTH,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             full;
    logic             empty;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign doPop    = pop & ~empty;
    // A push into a full buffer is only legal when the head leaves in the same cycle
    assign doPush   = push & (~full | doPop);
    assign headData = mem[rdPtr];

    // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            if (doPush && !doPop)      count <= count + CW'(1);
            else if (!doPush && doPop) count <= count - CW'(1);
        end
    end

    // Storage array; contents are qualified by count so it needs no reset
    always_ff @(posedge clk) begin
        if (!flush && doPush) mem[wrPtr] <= pushData;
    end

    overflowChk: assert property (@(posedge clk) disable iff (!reset)
        !(push && full && !pop && !flush));

    underflowChk: assert property (@(posedge clk) disable iff (!reset)
        !(pop && empty && !flush));

endmodule

// File: rtl/ifu_fetch_queue.sv
// Decoupled instruction-fetch front end feeding the IF/ID register.
// Issues in-order requests to a variable-latency instruction memory, keeps a
// small prefetch queue of {pc, ir} pairs, holds the head on IF/ID stalls and
// flushes on control-path redirects, discarding responses already in flight.
// Ports:
//   clk, reset               clock and asynchronous active-low reset
//   redirect, redirect_pc    taken jump/branch/jr: flush and refetch from redirect_pc
//   stall                    IF/ID hold; head entry is not consumed
//   imem_req, imem_addr      fetch request and word-aligned address
//   imem_gnt                 request accepted (req & gnt)
//   imem_rvalid, imem_rdata  in-order instruction response
//   out_valid, out_pc, out_ir  queue head; out_ir is a NOP when out_valid is low
module ifu_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   fpc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] dropCnt;
    logic [CW-1:0] qCount;
    logic [CW-1:0] sCount;
    logic [SW-1:0] creditSum;
    logic [31:0]   shadowPc;
    fetch_entry_t  headEntry;
    fetch_entry_t  pushEntry;
    logic          grant;
    logic          keepResp;
    logic          staleResp;
    logic          popHead;

    // Credit: every word in the queue or in flight already owns a queue slot,
    // so a returning response always has room
    assign creditSum = {1'b0, qCount} + {1'b0, outstanding};
    assign imem_req  = reset & ~redirect & (creditSum < SW'(DEPTH));
    assign imem_addr = fpc;
    assign grant     = imem_req & imem_gnt;

    // Responses issued before the last redirect are counted off by dropCnt
    assign keepResp  = imem_rvalid & ~redirect & (dropCnt == '0);
    assign staleResp = imem_rvalid & ~redirect & (dropCnt != '0);
    assign popHead   = out_valid & ~stall & ~redirect;

    assign pushEntry = '{pc: shadowPc, ir: imem_rdata};

    assign out_valid = (qCount != '0);
    assign out_pc    = out_valid ? headEntry.pc : 32'h0;
    assign out_ir    = out_valid ? headEntry.ir : NOP_INSTR;

    // Fetch PC, in-flight request count and stale-response count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc         <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else if (redirect) begin
            // imem_req is low during redirect, so nothing is granted this cycle;
            // everything still in flight, minus today's response, becomes stale
            fpc         <= alignPc(redirect_pc);
            outstanding <= outstanding - CW'(imem_rvalid);
            dropCnt     <= outstanding - CW'(imem_rvalid);
        end else begin
            if (grant) fpc <= fpc + 32'd4;
            if (grant && !imem_rvalid)      outstanding <= outstanding + CW'(1);
            else if (!grant && imem_rvalid) outstanding <= outstanding - CW'(1);
            if (staleResp) dropCnt <= dropCnt - CW'(1);
        end
    end

    // Prefetch queue of {pc, ir}
    fq_ring #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) entryQ (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push     (keepResp),
        .pushData (pushEntry),
        .pop      (popHead),
        .headData (headEntry),
        .count    (qCount)
    );

    // PCs of live requests, matched to responses in return order
    fq_ring #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) shadowQ (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push     (grant),
        .pushData (fpc),
        .pop      (keepResp),
        .headData (shadowPc),
        .count    (sCount)
    );

    // Every in-flight request is either stale or has a shadow PC
    shadowChk: assert property (@(posedge clk) disable iff (!reset)
        ({1'b0, sCount} + {1'b0, dropCnt}) == {1'b0, outstanding});

endmodule
